uart_tx_gen: RTL

Parametrised, synthesizable UART transmitter for the SoC test environment and FPGA top. It replaces the fixed 8N1/115200 byte-sending stimulus with a configurable engine: divisor-driven baud rate, 5–8 data bits, optional parity, and 1 or 2 stop bits, fed from a small byte FIFO. Its `tx` output drives the SoC UART RX pin, which is GPIO bit 16.

---
 rtl/uart_tx_pkg.sv | 23 ++
 rtl/uart_tx_fifo.sv | 52 +++++
 rtl/uart_tx_gen.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the configurable UART transmitter.
// Optional parity support is compiled in with the UART_TX_PARITY_EN macro.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_e;

    localparam int unsigned DBITS_BASE = 5;
    localparam int unsigned DIV_MIN    = 2;

    // Keep only the low 5..8 bits selected by the data-width code.
    function automatic logic [7:0] data_mask(input logic [1:0] dbits);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - dbits);
        return mask;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the transmitter; DEPTH must be a power of two, at least 2.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               wdata,
    input  logic                     pop,
    output logic [7:0]               rdata_c,
    output logic                     empty_c,
    output logic                     ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok_c;
    logic          pop_ok_c;
    logic [CW-1:0] count_d;

    assign push_ok_c = push && ready;
    assign pop_ok_c  = pop && !empty_c;
    assign empty_c   = (count == '0);
    assign rdata_c   = mem[rd_ptr];
    assign count_d   = count + CW'(push_ok_c) - CW'(pop_ok_c);

    // Pointers, occupancy and a registered not-full flag; a pop never frees a slot combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b1;
        end else begin
            if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok_c)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_d;
            ready <= (count_d != CW'(DEPTH));
        end
    end

    // Storage write; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok_c) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_gen.sv
// Configurable UART transmitter: divisor baud, 5-8 data bits, 1/2 stop bits.
// Parity bit support is present only when UART_TX_PARITY_EN is defined.
module uart_tx_gen
    import uart_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned DIV_RST    = 234
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic [1:0]                    cfg_dbits,
    input  logic                          cfg_stop2,
    input  logic                          cfg_par_en,
    input  logic                          cfg_par_odd,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_data,
    output logic                          tx,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    uart_tx_state_e   state_q, state_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [2:0]       last_bit_q, last_bit_d;
    logic [7:0]       data_q, data_d;
    logic             stop2_q, stop2_d;
    logic             stop_sec_q, stop_sec_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
`ifdef UART_TX_PARITY_EN
    logic             par_en_q, par_en_d;
    logic             par_odd_q, par_odd_d;
`else
    logic             unused_par_c;
    assign unused_par_c = cfg_par_en ^ cfg_par_odd;
`endif

    logic             load_c;
    logic             fifo_empty_c;
    logic [7:0]       fifo_rdata_c;
    logic [DIV_W-1:0] div_eff_c;

    assign div_eff_c = (cfg_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : cfg_div;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (in_valid),
        .wdata   (in_data),
        .pop     (load_c),
        .rdata_c (fifo_rdata_c),
        .empty_c (fifo_empty_c),
        .ready   (in_ready),
        .count   (fifo_count)
    );

    // State, frame and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            baud_q       <= '0;
            div_q        <= DIV_W'(DIV_RST);
            bit_q        <= '0;
            last_bit_q   <= '0;
            data_q       <= '0;
            stop2_q      <= 1'b0;
            stop_sec_q   <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            last_bit_q   <= last_bit_d;
            data_q       <= data_d;
            stop2_q      <= stop2_d;
            stop_sec_q   <= stop_sec_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
`ifdef UART_TX_PARITY_EN
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
`endif
        end
    end

    // Next-state, baud counting, frame latching and registered output values.
    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        div_d        = div_q;
        bit_d        = bit_q;
        last_bit_d   = last_bit_q;
        data_d       = data_q;
        stop2_d      = stop2_q;
        stop_sec_d   = stop_sec_q;
        load_c       = 1'b0;
        frame_done_d = 1'b0;
        tx_d         = 1'b1;
        busy_d       = (state_q != ST_IDLE) || !fifo_empty_c;
`ifdef UART_TX_PARITY_EN
        par_en_d     = par_en_q;
        par_odd_d    = par_odd_q;
`endif

        case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = data_q[bit_q];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = (^data_q) ^ par_odd_q;
`endif
            default:   tx_d = 1'b1;
        endcase

        if (state_q != ST_IDLE) begin
            baud_d = (baud_q == '0) ? div_q - DIV_W'(1) : baud_q - DIV_W'(1);
        end

        case (state_q)
            ST_IDLE: load_c = !fifo_empty_c;
            ST_START: begin
                if (baud_q == '0) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (baud_q == '0) begin
                    if (bit_q == last_bit_q) begin
                        stop_sec_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                        state_d    = par_en_q ? ST_PARITY : ST_STOP;
`else
                        state_d    = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_q == '0) begin
                    state_d    = ST_STOP;
                    stop_sec_d = 1'b0;
                end
            end
`endif
            ST_STOP: begin
                if (baud_q == '0) begin
                    if (stop2_q && !stop_sec_q) begin
                        stop_sec_d = 1'b1;
                    end else begin
                        frame_done_d = 1'b1;
                        if (!fifo_empty_c) load_c  = 1'b1;
                        else               state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pop the head byte and freeze the configuration for the whole frame.
        if (load_c) begin
            state_d    = ST_START;
            data_d     = fifo_rdata_c & data_mask(cfg_dbits);
            last_bit_d = 3'(DBITS_BASE - 1) + 3'(cfg_dbits);
            stop2_d    = cfg_stop2;
            stop_sec_d = 1'b0;
            div_d      = div_eff_c;
            baud_d     = div_eff_c - DIV_W'(1);
`ifdef UART_TX_PARITY_EN
            par_en_d   = cfg_par_en;
            par_odd_d  = cfg_par_odd;
`endif
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
